// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART controller: edge-detected capture, show-ahead read, sticky overflow.
// Optional fill-level port `count` is enabled by defining UART_RX_FIFO_CNT_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_rdy,
  input  logic                rd_en,
  input  logic                ovf_clr,
  output logic [DATA_W-1:0]   dout,
  output logic                empty,
  output logic                full,
  output logic                overflow
`ifdef UART_RX_FIFO_CNT_EN
  ,
  output logic [DEPTH_LOG2:0] count
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              rx_rdy_q;
  logic              wr_req, rd_ok, wr_ok;

  // A held rx_rdy level yields one write, on its rising edge.
  assign wr_req = rx_rdy & ~rx_rdy_q;
  assign rd_ok  = rd_en & ~empty;
  assign wr_ok  = wr_req & (~full | rd_ok);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                 (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

`ifdef UART_RX_FIFO_CNT_EN
  assign count = wr_ptr - rd_ptr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_rdy_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_rdy_q <= rx_rdy;
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      // A new drop takes priority over a clear in the same cycle.
      if (wr_req & full & ~rd_ok) overflow <= 1'b1;
      else if (ovf_clr)           overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: hand-computed expectations for capture, drain order, full/overflow and reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy, rd_en, ovf_clr;
  logic [7:0] dout;
  logic       empty, full, overflow;
`ifdef UART_RX_FIFO_CNT_EN
  logic [4:0] count;
`endif

  int n_vec = 0;
  int n_err = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .dout(dout), .empty(empty), .full(full), .overflow(overflow)
`ifdef UART_RX_FIFO_CNT_EN
    , .count(count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef UART_RX_FIFO_CNT_EN
    chk(tag, 32'(count), exp);
`endif
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b; rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(dout), 32'(exp));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_rdy = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk_cnt("rst_cnt", 0);
    rst = 1'b0;
    tick();

    // single byte: visible one cycle after rx_rdy rises
    rx_data = 8'hA5; rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    chk("t1_empty", 32'(empty), 0);
    chk("t1_dout", 32'(dout), 32'hA5);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t1_drained", 32'(empty), 1);

    // held level gives one entry
    rx_data = 8'h3C; rx_rdy = 1'b1;
    repeat (5) tick();
    rx_rdy = 1'b0;
    tick();
    chk_cnt("t2_cnt", 1);
    pop_chk("t2_dout", 8'h3C);
    chk("t2_empty", 32'(empty), 1);

    // pop while empty is ignored
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rd_empty_ign", 32'(empty), 1);
    chk_cnt("rd_empty_cnt", 0);

    // write + read on empty: write only, no bypass
    rx_data = 8'h5A; rx_rdy = 1'b1; rd_en = 1'b1;
    tick();
    rx_rdy = 1'b0; rd_en = 1'b0;
    chk("wr_rd_empty", 32'(empty), 0);
    chk_cnt("wr_rd_empty_cnt", 1);
    pop_chk("wr_rd_empty_dout", 8'h5A);

    // fill, drop, drain
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t3_full", 32'(full), 1);
    chk("t3_ovf0", 32'(overflow), 0);
    chk_cnt("t3_cnt", 16);
    push(8'hFF);
    chk("t3_ovf1", 32'(overflow), 1);
    chk_cnt("t3_cnt_drop", 16);
    for (int i = 0; i < 16; i++) pop_chk("t3_order", 8'(i));
    chk("t3_empty", 32'(empty), 1);

    // clear overflow
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t5_clr", 32'(overflow), 0);

    // full with simultaneous write and pop
    for (int i = 0; i < 16; i++) push(8'(i));
    rx_data = 8'h77; rx_rdy = 1'b1; rd_en = 1'b1;
    tick();
    rx_rdy = 1'b0; rd_en = 1'b0;
    chk("t4_full", 32'(full), 1);
    chk("t4_ovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) pop_chk("t4_order", 8'(i));
    pop_chk("t4_last", 8'h77);
    chk("t4_empty", 32'(empty), 1);

    // drop concurrent with clear: set wins
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    push(8'hEE);
    chk("t5_ovf_set", 32'(overflow), 1);
    rx_data = 8'hEF; rx_rdy = 1'b1; ovf_clr = 1'b1;
    tick();
    rx_rdy = 1'b0; ovf_clr = 1'b0;
    chk("t5_set_wins", 32'(overflow), 1);
    tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("t5_clr2", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) pop_chk("t5_order", 8'h40 + 8'(i));
    chk("t5_empty", 32'(empty), 1);

    // interleaved 20 writes / 20 reads across pointer wrap
    for (int i = 0; i < 20; i += 2) begin
      push(8'h80 + 8'(i));
      push(8'h80 + 8'(i + 1));
      pop_chk("t6_order", 8'h80 + 8'(i));
      pop_chk("t6_order", 8'h80 + 8'(i + 1));
    end
    chk("t6_empty", 32'(empty), 1);

    // fill past full, then reset mid-stream
    for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
    chk("t6_ovf_pre", 32'(overflow), 1);
    chk("t6_dout_pre", 32'(dout), 32'hC0);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("t6_rst_empty", 32'(empty), 1);
    chk("t6_rst_full", 32'(full), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    chk_cnt("t6_rst_cnt", 0);
    push(8'h11);
    pop_chk("t6_post_rst", 8'h11);
    chk("t6_post_empty", 32'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
